johnson_decoder: RTL and testbench

JOHNSON_DECODER -- requirements
Module: johnson_decoder

---
 rtl/johnson_decoder.sv | 138 +++++++++++++
 tb/tb_johnson_decoder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/johnson_decoder.sv
// Johnson-code decoder with successor tracking, lock FSM and saturating error counter.
// Optional JOHNSON_DEC_RESYNC_EN: errors in LOCKED return to HUNT instead of a sticky ERROR.
module johnson_decoder #(
    parameter int LOCK_COUNT = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Code_in,
    input  logic       Code_valid,
    output logic [2:0] Count_out,
    output logic       Decode_valid,
    output logic       Illegal_code,
    output logic       Seq_error,
    output logic       Locked,
    output logic [7:0] Error_count
);

    typedef enum logic [1:0] {HUNT, LOCKED, ERROR} state_t;

    localparam logic [4:0] LOCK_CNT = 5'(LOCK_COUNT);

    state_t     state, state_n;
    logic [3:0] run, run_n;
    logic       ref_vld, ref_vld_n;
    logic [2:0] ref_idx, ref_idx_n;
    logic [2:0] count_n;
    logic       dv_n, ill_n, seq_n;
    logic [7:0] err_n;

    logic       legal;
    logic [2:0] idx;
    logic [2:0] nxt_idx;
    logic       succ;
    logic [4:0] run_inc;

    always_comb begin
        legal = 1'b1;
        idx   = 3'd0;
        case (Code_in)
            4'b0000: idx = 3'd0;
            4'b0001: idx = 3'd1;
            4'b0011: idx = 3'd2;
            4'b0111: idx = 3'd3;
            4'b1111: idx = 3'd4;
            4'b1110: idx = 3'd5;
            4'b1100: idx = 3'd6;
            4'b1000: idx = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    // A repeated code is never a successor; 7 -> 0 wraps naturally in 3 bits.
    assign nxt_idx = ref_idx + 3'd1;
    assign succ    = ref_vld && legal && (idx == nxt_idx);
    assign run_inc = {1'b0, run} + 5'd1;

    always_comb begin
        state_n   = state;
        run_n     = run;
        ref_vld_n = ref_vld;
        ref_idx_n = ref_idx;
        count_n   = Count_out;
        dv_n      = 1'b0;
        ill_n     = 1'b0;
        seq_n     = 1'b0;
        err_n     = Error_count;
        if (Code_valid) begin
            dv_n = 1'b1;
            if (legal) count_n = idx;
            case (state)
                HUNT: begin
                    if (!legal) begin
                        run_n     = 4'd0;
                        ref_vld_n = 1'b0;
                    end else if (succ) begin
                        ref_idx_n = idx;
                        if (run_inc >= LOCK_CNT) begin
                            run_n   = 4'd0;
                            state_n = LOCKED;
                        end else begin
                            run_n = run_inc[3:0];
                        end
                    end else begin
                        run_n     = 4'd0;
                        ref_vld_n = 1'b1;
                        ref_idx_n = idx;
                    end
                end
                LOCKED: begin
                    if (succ) begin
                        ref_idx_n = idx;
                    end else begin
                        seq_n = 1'b1;
                        ill_n = !legal;
                        if (Error_count != 8'hFF) err_n = Error_count + 8'd1;
`ifdef JOHNSON_DEC_RESYNC_EN
                        state_n   = HUNT;
                        run_n     = 4'd0;
                        ref_vld_n = legal;
                        if (legal) ref_idx_n = idx;
`else
                        state_n = ERROR;
`endif
                    end
                end
                ERROR:   ;
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= HUNT;
            run          <= 4'd0;
            ref_vld      <= 1'b0;
            ref_idx      <= 3'd0;
            Count_out    <= 3'd0;
            Decode_valid <= 1'b0;
            Illegal_code <= 1'b0;
            Seq_error    <= 1'b0;
            Error_count  <= 8'd0;
        end else begin
            state        <= state_n;
            run          <= run_n;
            ref_vld      <= ref_vld_n;
            ref_idx      <= ref_idx_n;
            Count_out    <= count_n;
            Decode_valid <= dv_n;
            Illegal_code <= ill_n;
            Seq_error    <= seq_n;
            Error_count  <= err_n;
        end
    end

    assign Locked = (state == LOCKED);

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (LOCK_COUNT=2), immediate-assertion checking.
module tb_johnson_decoder;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Code_in = 4'd0;
    logic       Code_valid = 1'b0;
    logic [2:0] Count_out;
    logic       Decode_valid, Illegal_code, Seq_error, Locked;
    logic [7:0] Error_count;

    int checks = 0;
    int errors = 0;

    logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000};

    johnson_decoder #(.LOCK_COUNT(2)) dut (
        .Clock(Clock), .Reset(Reset), .Code_in(Code_in), .Code_valid(Code_valid),
        .Count_out(Count_out), .Decode_valid(Decode_valid), .Illegal_code(Illegal_code),
        .Seq_error(Seq_error), .Locked(Locked), .Error_count(Error_count)
    );

    always #5 Clock = ~Clock;

    // Drive on the falling edge, sample 1ns after the rising edge.
    task automatic step(input logic rst, input logic vld, input logic [3:0] code);
        @(negedge Clock);
        Reset      = rst;
        Code_valid = vld;
        Code_in    = code;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int dv, input int cnt, input int ill,
                           input int seq, input int lck, input int err);
        chk({tag, ".dv"},  int'(Decode_valid), dv);
        chk({tag, ".cnt"}, int'(Count_out),    cnt);
        chk({tag, ".ill"}, int'(Illegal_code), ill);
        chk({tag, ".seq"}, int'(Seq_error),    seq);
        chk({tag, ".lck"}, int'(Locked),       lck);
        chk({tag, ".err"}, int'(Error_count),  err);
    endtask

    initial begin
        // Reset state
        step(1, 0, 4'd0);
        chk_all("reset", 0, 0, 0, 0, 0, 0);

        // Lock acquisition on three consecutive codes
        step(0, 1, 4'b0000); chk_all("acq0", 1, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0001); chk_all("acq1", 1, 1, 0, 0, 0, 0);
        step(0, 1, 4'b0011); chk_all("acq2", 1, 2, 0, 0, 1, 0);
        step(0, 0, 4'b1010); chk_all("idle", 0, 2, 0, 0, 1, 0);

        // Locked walk across the 7 -> 0 wrap
        for (int i = 3; i <= 8; i++) begin
            step(0, 1, codes[i % 8]);
            chk_all($sformatf("walk%0d", i), 1, i % 8, 0, 0, 1, 0);
        end

        // Five-cycle gap keeps lock
        for (int i = 0; i < 5; i++) step(0, 0, 4'b0110);
        chk_all("gap_idle", 0, 0, 0, 0, 1, 0);
        step(0, 1, 4'b0001); chk_all("gap1", 1, 1, 0, 0, 1, 0);
        step(0, 1, 4'b0011); chk_all("gap2", 1, 2, 0, 0, 1, 0);
        step(0, 1, 4'b0111); chk_all("gap3", 1, 3, 0, 0, 1, 0);

        // Illegal code while locked at index 3
        step(0, 1, 4'b0101); chk_all("illegal", 1, 3, 1, 1, 0, 1);
`ifdef JOHNSON_DEC_RESYNC_EN
        step(0, 1, 4'b1111); chk_all("rs_ref",  1, 4, 0, 0, 0, 1);
        step(0, 1, 4'b1110); chk_all("rs_run1", 1, 5, 0, 0, 0, 1);
        step(0, 1, 4'b1100); chk_all("rs_lock", 1, 6, 0, 0, 1, 1);
`else
        step(0, 1, 4'b1111); chk_all("err_dec0", 1, 4, 0, 0, 0, 1);
        step(0, 1, 4'b1110); chk_all("err_dec1", 1, 5, 0, 0, 0, 1);
        step(0, 1, 4'b1100); chk_all("err_dec2", 1, 6, 0, 0, 0, 1);
        step(0, 1, 4'b0101); chk_all("err_ill",  1, 6, 0, 0, 0, 1);
        step(0, 1, 4'b0011); chk_all("err_skip", 1, 2, 0, 0, 0, 1);
`endif

        // Skipped code while locked
        step(1, 0, 4'd0);    chk_all("rst2", 0, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0000);
        step(0, 1, 4'b0001);
        step(0, 1, 4'b0011); chk_all("relock", 1, 2, 0, 0, 1, 0);
        step(0, 1, 4'b1111); chk_all("skip", 1, 4, 0, 1, 0, 1);

        // Reset coincident with a sample while locked
        step(1, 0, 4'd0);
        step(0, 1, 4'b0000);
        step(0, 1, 4'b0001);
        step(0, 1, 4'b0011); chk_all("lock3", 1, 2, 0, 0, 1, 0);
        step(1, 1, 4'b0111); chk_all("rst_sample", 0, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0111); chk_all("post_ref", 1, 3, 0, 0, 0, 0);
        step(0, 1, 4'b1111); chk_all("post_run", 1, 4, 0, 0, 0, 0);
        step(0, 1, 4'b1110); chk_all("post_lock", 1, 5, 0, 0, 1, 0);

`ifdef JOHNSON_DEC_RESYNC_EN
        // Saturation: locked at 5; skip two, then relock with two successors
        begin
            int cur = 5;
            for (int n = 0; n < 300; n++) begin
                cur = (cur + 2) % 8; step(0, 1, codes[cur]);
                cur = (cur + 1) % 8; step(0, 1, codes[cur]);
                cur = (cur + 1) % 8; step(0, 1, codes[cur]);
            end
            chk("sat.err", int'(Error_count), 255);
            chk("sat.lck", int'(Locked), 1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
